// File: rtl/z_angle_pkg.sv
// Shared constants for the angle ROM and the round-robin pick function used by
// the ROM arbiter.
package z_angle_pkg;

    localparam int ANGLE_ADDR_WIDTH  = 10;
    localparam int ANGLE_DATA_WIDTH  = 32;
    localparam bit ANGLE_OUTPUT_REG  = 1'b0;
    localparam int ANGLE_ROM_LATENCY = ANGLE_OUTPUT_REG ? 2 : 1;
    localparam int RR_MAX_REQ        = 8;

    // Returns the first set index at or after ptr (mod n), or -1 when req is empty.
    // The scan runs from the far end so the nearest candidate is written last.
    function automatic int rr_pick(input logic [RR_MAX_REQ-1:0] req,
                                   input int ptr,
                                   input int n);
        int sel;
        int idx;
        sel = -1;
        for (int k = RR_MAX_REQ - 1; k >= 0; k--) begin
            if (k < n) begin
                idx = (ptr + k) % n;
                if (req[idx]) begin
                    sel = idx;
                end
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/z_angle_rom_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant plus the winner's index,
// starting the search at ptr.
module rr_arbiter
    import z_angle_pkg::*;
#(
    parameter int N = 4,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    logic [RR_MAX_REQ-1:0] req_ext;
    int                    sel;

    always_comb begin
        req_ext        = '0;
        req_ext[N-1:0] = req;
        sel            = rr_pick(req_ext, int'(ptr), N);
        gnt            = '0;
        gnt_idx        = '0;
        if (sel >= 0) begin
            gnt_idx  = IDX_W'(sel);
            gnt[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/z_angle_rom_arbiter.sv
// Shares one single-port angle ROM between N_REQ CORDIC engines: round-robin
// issue, one read per clock, one-hot tagged responses after ROM_LATENCY cycles.
module z_angle_rom_arbiter
    import z_angle_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int ADDR_WIDTH  = ANGLE_ADDR_WIDTH,
    parameter int DATA_WIDTH  = ANGLE_DATA_WIDTH,
    parameter int ROM_LATENCY = ANGLE_ROM_LATENCY
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [N_REQ-1:0]            req_ready,
    output logic [N_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]       rsp_data,
    output logic                        busy,
    output logic [ADDR_WIDTH-1:0]       rom_addr,
    output logic                        rom_clk_en,
    input  logic [DATA_WIDTH-1:0]       rom_rd_data
);

    localparam int IDX_W = $clog2(N_REQ);

    logic [IDX_W-1:0]       ptr;
    logic [IDX_W-1:0]       gnt_idx;
    logic [N_REQ-1:0]       gnt;
    logic [N_REQ-1:0]       req_live;
    logic                   gnt_any;
    logic [ADDR_WIDTH-1:0]  win_addr;
    logic [ADDR_WIDTH-1:0]  addr_hold;
    logic [ROM_LATENCY-1:0] vld_p;
    logic [N_REQ-1:0]       tag_p [ROM_LATENCY];

    // Requests are masked while reset is held so nothing is granted or driven.
    assign req_live = req_valid & {N_REQ{rst_n}};

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req     (req_live),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign gnt_any   = |gnt;
    assign req_ready = gnt;
    assign win_addr  = req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign rom_addr  = gnt_any ? win_addr : addr_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            addr_hold <= '0;
        end else if (gnt_any) begin
            addr_hold <= win_addr;
            ptr       <= (int'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Tag pipeline: stage 0 captures the issue, the last stage lines up with rd_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p <= '0;
            for (int k = 0; k < ROM_LATENCY; k++) begin
                tag_p[k] <= '0;
            end
        end else begin
            vld_p[0] <= gnt_any;
            tag_p[0] <= gnt;
            for (int k = 1; k < ROM_LATENCY; k++) begin
                vld_p[k] <= vld_p[k-1];
                tag_p[k] <= tag_p[k-1];
            end
        end
    end

    assign rsp_valid  = tag_p[ROM_LATENCY-1] & {N_REQ{vld_p[ROM_LATENCY-1]}};
    assign rsp_data   = rom_rd_data;
    assign busy       = |vld_p;
    assign rom_clk_en = gnt_any | busy;

endmodule

// File: tb/tb_z_angle_rom_arbiter.sv
// Bench for z_angle_rom_arbiter: latency-1 and latency-2 instances share stimulus
// and are compared each cycle against a grant-history reference model.
module tb_z_angle_rom_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [39:0] req_addr = '0;

    logic [3:0]  ready1, ready2, rspv1, rspv2;
    logic [31:0] rspd1, rspd2, rd1, rd2, rd2_int;
    logic        busy1, busy2, en1, en2;
    logic [9:0]  ra1, ra2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    z_angle_rom_arbiter #(.N_REQ(4), .ADDR_WIDTH(10), .DATA_WIDTH(32), .ROM_LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(ready1), .rsp_valid(rspv1), .rsp_data(rspd1), .busy(busy1),
        .rom_addr(ra1), .rom_clk_en(en1), .rom_rd_data(rd1)
    );

    z_angle_rom_arbiter #(.N_REQ(4), .ADDR_WIDTH(10), .DATA_WIDTH(32), .ROM_LATENCY(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(ready2), .rsp_valid(rspv2), .rsp_data(rspd2), .busy(busy2),
        .rom_addr(ra2), .rom_clk_en(en2), .rom_rd_data(rd2)
    );

    function automatic logic [31:0] rom_f(input logic [9:0] a);
        return {a, 22'h0} ^ (32'(a) * 32'h9E37_79B1) ^ 32'h0F0F_1234;
    endfunction

    // Behavioural ROMs: registered read, plus optional output register.
    always @(posedge clk) begin
        if (en1) rd1 <= rom_f(ra1);
        if (en2) begin
            rd2_int <= rom_f(ra2);
            rd2     <= rd2_int;
        end
    end

    // Reference model state: grant issued in each cycle, pointer, address hold.
    logic [3:0] hist_tag  [0:1023];
    logic [9:0] hist_addr [0:1023];
    int         cyc = 0;
    int         mptr = 0;
    logic [9:0] mhold = '0;
    logic [3:0] egnt;
    logic [9:0] eaddr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_dut(input string nm, input int lat,
                           input logic [3:0] rdy, input logic [3:0] rv, input logic [31:0] rd,
                           input logic bsy, input logic en, input logic [9:0] ra);
        logic [3:0] t;
        logic       eb;
        t  = (cyc - lat >= 0) ? hist_tag[cyc-lat] : 4'b0;
        eb = 1'b0;
        for (int j = 1; j <= lat; j++)
            if (cyc - j >= 0 && hist_tag[cyc-j] != 4'b0) eb = 1'b1;
        chk({nm, ".req_ready"}, 64'(rdy), 64'(egnt));
        chk({nm, ".rsp_valid"}, 64'(rv), 64'(t));
        if (t != 4'b0) chk({nm, ".rsp_data"}, 64'(rd), 64'(rom_f(hist_addr[cyc-lat])));
        chk({nm, ".busy"}, 64'(bsy), 64'(eb));
        chk({nm, ".rom_clk_en"}, 64'(en), 64'((egnt != 4'b0) | eb));
        chk({nm, ".rom_addr"}, 64'(ra), 64'((egnt != 4'b0) ? eaddr : mhold));
    endtask

    // One clock of stimulus; use_lit adds a hard expectation on the latency-1 grant.
    task automatic step(input logic [3:0] v, input logic [39:0] a, input logic r,
                        input bit use_lit, input logic [3:0] lit);
        bit found;
        int w;
        @(negedge clk);
        rst_n     = r;
        req_valid = v;
        req_addr  = a;
        #1;
        egnt  = '0;
        eaddr = '0;
        if (!r) begin
            for (int i = 0; i < 1024; i++) begin
                hist_tag[i]  = '0;
                hist_addr[i] = '0;
            end
            mptr  = 0;
            mhold = '0;
        end else begin
            found = 1'b0;
            for (int k = 0; k < 4; k++) begin
                w = (mptr + k) % 4;
                if (!found && v[w]) begin
                    found = 1'b1;
                    egnt  = 4'b0001 << w;
                    eaddr = a[w*10 +: 10];
                end
            end
        end
        hist_tag[cyc]  = egnt;
        hist_addr[cyc] = eaddr;
        chk_dut("lat1", 1, ready1, rspv1, rspd1, busy1, en1, ra1);
        chk_dut("lat2", 2, ready2, rspv2, rspd2, busy2, en2, ra2);
        if (use_lit) chk("directed_grant", 64'(ready1), 64'(lit));
        if (egnt != 4'b0) begin
            for (int i = 0; i < 4; i++)
                if (egnt[i]) mptr = (i + 1) % 4;
            mhold = eaddr;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(4'b0, 40'h0, 1'b1, 1'b0, 4'b0);
    endtask

    task automatic do_reset();
        step(4'b0, 40'h0, 1'b0, 1'b0, 4'b0);
        step(4'b0, 40'h0, 1'b0, 1'b0, 4'b0);
    endtask

    logic [3:0]  pv;
    logic [39:0] pa;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            hist_tag[i]  = '0;
            hist_addr[i] = '0;
        end

        // Reset, then idle with nothing pending
        do_reset();
        idle(20);

        // Single read: requester 2 at address 0x005
        do_reset();
        step(4'b0100, {10'h0, 10'h005, 10'h0, 10'h0}, 1'b1, 1'b1, 4'b0100);
        idle(3);

        // Full contention, addresses 0..3 held for 8 cycles
        do_reset();
        for (int i = 0; i < 8; i++)
            step(4'b1111, {10'd3, 10'd2, 10'd1, 10'd0}, 1'b1, 1'b1, 4'b0001 << (i % 4));
        idle(3);

        // Sole requester 1 back to back: addresses 10, 11, 12
        for (int i = 0; i < 3; i++)
            step(4'b0010, {10'h0, 10'h0, 10'(10 + i), 10'h0}, 1'b1, 1'b1, 4'b0010);
        idle(3);

        // Wrap: move ptr to 3, then requesters 3 and 0 -> 3, 0, then ptr at 1
        do_reset();
        step(4'b0100, {10'h0, 10'h22, 10'h0, 10'h0}, 1'b1, 1'b1, 4'b0100);
        step(4'b1001, {10'h33, 10'h0, 10'h0, 10'h30}, 1'b1, 1'b1, 4'b1000);
        step(4'b0001, {10'h0, 10'h0, 10'h0, 10'h30}, 1'b1, 1'b1, 4'b0001);
        step(4'b1111, {10'h3, 10'h2, 10'h1, 10'h0}, 1'b1, 1'b1, 4'b0010);
        idle(3);

        // Reset in the cycle after a grant: nothing must come back
        step(4'b0010, {10'h0, 10'h0, 10'h07, 10'h0}, 1'b1, 1'b1, 4'b0010);
        step(4'b0, 40'h0, 1'b0, 1'b0, 4'b0);
        step(4'b0, 40'h0, 1'b0, 1'b0, 4'b0);
        idle(6);

        // Randomized traffic; requesters hold until accepted
        pv = '0;
        pa = '0;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 4; i++) begin
                if (!pv[i] && $urandom_range(0, 2) != 0) begin
                    pv[i]          = 1'b1;
                    pa[i*10 +: 10] = 10'($urandom);
                end
            end
            step(pv, pa, 1'b1, 1'b0, 4'b0);
            pv = pv & ~egnt;
        end
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
